// File: rtl/hash_batch_route_node.sv
// Hash batch routing node: delivers each beat to its local PE port or forwards it to the next node.
// Optional macro HASH_BATCH_BCAST_EN enables broadcast beats (all local ports plus next).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef JOB_LEN_LOG2
`define JOB_LEN_LOG2 4
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif

module hash_batch_route_node #(
   parameter int NUM_LOCAL  = 2,
   parameter int IDX_BASE   = 0,
   parameter int PE_IDX_LSB = `JOB_LEN_LOG2,
   parameter int PE_IDX_W   = `NUM_JOB_PE_LOG2,
   parameter int PAYLOAD_W  = 64,
   parameter int NEXT_DEPTH = 2,
   localparam int LEVEL_W   = (NEXT_DEPTH < 1) ? 1 : $clog2(NEXT_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [`ADDR_WIDTH-1:0] i_head_addr,
   input  logic [PAYLOAD_W-1:0]   i_payload,
   input  logic                   i_bcast,
   output logic [NUM_LOCAL-1:0]   o_local_valid,
   input  logic [NUM_LOCAL-1:0]   o_local_ready,
   output logic [`ADDR_WIDTH-1:0] o_local_head_addr,
   output logic [PAYLOAD_W-1:0]   o_local_payload,
   output logic                   o_local_bcast,
   output logic                   o_next_valid,
   input  logic                   o_next_ready,
   output logic [`ADDR_WIDTH-1:0] o_next_head_addr,
   output logic [PAYLOAD_W-1:0]   o_next_payload,
   output logic                   o_next_bcast,
   output logic [LEVEL_W-1:0]     o_next_level
);
`ifdef HASH_BATCH_BCAST_EN
   localparam logic BCAST_EN = 1'b1;
`else
   localparam logic BCAST_EN = 1'b0;
`endif
   // Destination index NUM_LOCAL is the downstream (next) side.
   localparam int ND = NUM_LOCAL + 1;
   localparam logic [31:0] BASE  = 32'(IDX_BASE);
   localparam logic [31:0] LIMIT = 32'(IDX_BASE + NUM_LOCAL);

   logic                bcast;
   logic [PE_IDX_W-1:0] pe;
   logic [31:0]         pe_w;
   logic [31:0]         local_sel;
   logic                is_local;
   logic [ND-1:0]       dest;
   logic [ND-1:0]       done;
   logic [ND-1:0]       valid;
   logic [ND-1:0]       ready;
   logic [ND-1:0]       accept;
   logic                next_valid;
   logic                next_ready;

   assign bcast     = BCAST_EN & i_bcast;
   assign pe        = i_head_addr[PE_IDX_LSB +: PE_IDX_W];
   assign pe_w      = 32'(pe);
   assign local_sel = pe_w - BASE;
   assign is_local  = (pe_w >= BASE) && (pe_w < LIMIT);

   always_comb begin
      dest = '0;
      for (int i = 0; i < NUM_LOCAL; i++)
         dest[i] = bcast | (is_local & (local_sel == 32'(i)));
      dest[NUM_LOCAL] = bcast | ~is_local;
   end

   assign ready         = {next_ready, o_local_ready};
   assign valid         = {ND{i_valid & ~rst}} & dest & ~done;
   assign accept        = valid & ready;
   assign i_ready       = ~rst & (&(~dest | done | accept));
   assign o_local_valid = valid[NUM_LOCAL-1:0];
   assign next_valid    = valid[NUM_LOCAL];

   assign o_local_head_addr = i_head_addr;
   assign o_local_payload   = i_payload;
   assign o_local_bcast     = bcast;

`ifdef HASH_BATCH_BCAST_EN
   // Remembers which destinations already took a partially delivered broadcast beat.
   always_ff @(posedge clk) begin
      if (rst)
         done <= '0;
      else if (i_valid & i_ready)
         done <= '0;
      else
         done <= done | accept;
   end
`else
   // A single-destination beat completes in the cycle it is accepted.
   assign done = '0;
`endif

   generate
      if (NEXT_DEPTH == 0) begin : g_direct
         assign next_ready       = o_next_ready;
         assign o_next_valid     = next_valid;
         assign o_next_head_addr = i_head_addr;
         assign o_next_payload   = i_payload;
         assign o_next_bcast     = bcast;
         assign o_next_level     = '0;
      end else begin : g_fifo
         localparam int PTR_W = (NEXT_DEPTH > 1) ? $clog2(NEXT_DEPTH) : 1;
         localparam logic [PTR_W-1:0]   LAST = PTR_W'(NEXT_DEPTH - 1);
         localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(NEXT_DEPTH);

         logic [`ADDR_WIDTH-1:0] head_mem    [NEXT_DEPTH];
         logic [PAYLOAD_W-1:0]   payload_mem [NEXT_DEPTH];
         logic                   bcast_mem   [NEXT_DEPTH];
         logic [PTR_W-1:0]       wr_ptr;
         logic [PTR_W-1:0]       rd_ptr;
         logic [LEVEL_W-1:0]     count;
         logic                   push;
         logic                   pop;

         // No full bypass: a full buffer refuses a push even while it is being popped.
         assign next_ready       = (count < FULL);
         assign push             = next_valid & next_ready;
         assign o_next_valid     = ~rst & (count != '0);
         assign pop              = o_next_valid & o_next_ready;
         assign o_next_level     = rst ? '0 : count;
         assign o_next_head_addr = head_mem[rd_ptr];
         assign o_next_payload   = payload_mem[rd_ptr];
         assign o_next_bcast     = BCAST_EN & bcast_mem[rd_ptr];

         always_ff @(posedge clk) begin
            if (rst) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               count  <= '0;
            end else begin
               if (push)
                  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
               if (pop)
                  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
               if (push & ~pop)
                  count <= count + 1'b1;
               else if (pop & ~push)
                  count <= count - 1'b1;
            end
         end

         // Storage is data only and is deliberately left out of reset.
         always_ff @(posedge clk) begin
            if (push) begin
               head_mem[wr_ptr]    <= i_head_addr;
               payload_mem[wr_ptr] <= i_payload;
               bcast_mem[wr_ptr]   <= bcast;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_hash_batch_route_node.sv
// Bench for hash_batch_route_node: directed cases plus randomized traffic against a queue-based model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_hash_batch_route_node;
   localparam int AW = `ADDR_WIDTH;
   localparam int PW = 16;
`ifdef HASH_BATCH_BCAST_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_ready;
   logic [AW-1:0] i_head_addr = '0;
   logic [PW-1:0] i_payload = '0;
   logic          i_bcast = 1'b0;
   logic [1:0]    o_local_valid;
   logic [1:0]    lrdy = 2'b00;
   logic [AW-1:0] o_local_head_addr;
   logic [PW-1:0] o_local_payload;
   logic          o_local_bcast;
   logic          o_next_valid;
   logic          nrdy = 1'b0;
   logic [AW-1:0] o_next_head_addr;
   logic [PW-1:0] o_next_payload;
   logic          o_next_bcast;
   logic [1:0]    o_next_level;

   int errors = 0;
   int checks = 0;
   bit rand_rdy = 1'b0;
   bit counting = 1'b0;
   int obs_cnt[3] = '{0, 0, 0};
   int exp_cnt[3] = '{0, 0, 0};

   hash_batch_route_node #(
      .NUM_LOCAL(2), .IDX_BASE(2), .PE_IDX_LSB(4), .PE_IDX_W(2),
      .PAYLOAD_W(PW), .NEXT_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(i_ready),
      .i_head_addr(i_head_addr), .i_payload(i_payload), .i_bcast(i_bcast),
      .o_local_valid(o_local_valid), .o_local_ready(lrdy),
      .o_local_head_addr(o_local_head_addr), .o_local_payload(o_local_payload),
      .o_local_bcast(o_local_bcast),
      .o_next_valid(o_next_valid), .o_next_ready(nrdy),
      .o_next_head_addr(o_next_head_addr), .o_next_payload(o_next_payload),
      .o_next_bcast(o_next_bcast), .o_next_level(o_next_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Destination set {next, port1, port0} from the routing rules: pe 2..3 is local, else next.
   function automatic logic [2:0] dest_of(input logic [AW-1:0] h, input logic b);
      int pe;
      logic [2:0] d;
      d = 3'b000;
      pe = int'((h >> 4) & 32'd3);
      if (BC && b) return 3'b111;
      if (pe >= 2 && pe < 4) d[pe - 2] = 1'b1;
      else d[2] = 1'b1;
      return d;
   endfunction

   // Model: set of destinations already served for the current beat, and a 2-entry queue downstream.
   logic [2:0]      got = 3'b000;
   logic [AW+PW:0]  nq[$];

   always @(negedge clk) begin
      logic [2:0] d, ev, acc;
      bit nr, er;
      d   = dest_of(i_head_addr, i_bcast);
      nr  = (nq.size() < 2);
      ev  = (i_valid && !rst) ? (d & ~got) : 3'b000;
      acc = ev & {nr, lrdy};
      er  = !rst && i_valid && ((~d | got | acc) == 3'b111);
      check("local_valid", o_local_valid, ev[1:0]);
      check("i_ready", i_ready, er);
      check("next_valid", o_next_valid, !rst && nq.size() != 0);
      check("next_level", o_next_level, rst ? 0 : nq.size());
      if (!rst && nq.size() != 0)
         check("next_data", {o_next_bcast, o_next_head_addr, o_next_payload}, nq[0]);
      if (i_valid)
         check("local_data", {o_local_bcast, o_local_head_addr, o_local_payload},
               {BC & i_bcast, i_head_addr, i_payload});
      if (rst) begin
         got = 3'b000;
         nq.delete();
      end else begin
         if (counting) begin
            for (int p = 0; p < 2; p++)
               if (o_local_valid[p] && lrdy[p]) obs_cnt[p]++;
            if (o_next_valid && nrdy) obs_cnt[2]++;
         end
         if (nq.size() != 0 && nrdy) void'(nq.pop_front());
         if (acc[2]) nq.push_back({BC & i_bcast, i_head_addr, i_payload});
         if (er) got = 3'b000;
         else got = got | acc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) begin
         lrdy = 2'($urandom);
         nrdy = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic present(input logic [AW-1:0] h, input logic [PW-1:0] p, input logic b);
      i_head_addr = h;
      i_payload   = p;
      i_bcast     = b;
      i_valid     = 1'b1;
   endtask

   task automatic wait_hs();
      bit hs;
      hs = 1'b0;
      for (int c = 0; c < 200 && !hs; c++) begin
         @(negedge clk);
         hs = i_valid && i_ready;
         tick();
      end
      if (!hs) check("handshake_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with traffic offered
      lrdy = 2'b11; nrdy = 1'b1;
      present(32'h30, 16'h0, 1'b0);
      tick(); tick(); #2;
      check("rst_local_valid", o_local_valid, 2'b00);
      check("rst_i_ready", i_ready, 0);
      check("rst_next_valid", o_next_valid, 0);
      check("rst_level", o_next_level, 0);
      tick();
      rst = 1'b0; i_valid = 1'b0; nrdy = 1'b0;

      // Single-target routing
      present(32'h30, 16'h1111, 1'b0); #2;
      check("pe3_local", o_local_valid, 2'b10);
      check("pe3_ready", i_ready, 1);
      check("pe3_next", o_next_valid, 0);
      tick();
      present(32'h20, 16'h2222, 1'b0); #2;
      check("pe2_local", o_local_valid, 2'b01);
      tick();
      present(32'h00, 16'h3333, 1'b0); #2;
      check("pe0_local", o_local_valid, 2'b00);
      check("pe0_ready", i_ready, 1);
      tick();
      i_valid = 1'b0; #2;
      check("pe0_level", o_next_level, 1);
      check("pe0_next_head", o_next_head_addr, 32'h00);
      check("pe0_next_payload", o_next_payload, 16'h3333);
      nrdy = 1'b1;
      tick();
      nrdy = 1'b0; #2;
      check("pe0_drained", o_next_level, 0);

      // Back-pressure, full buffer without bypass
      present(32'h10, 16'h0001, 1'b0); #2;
      check("bp_beat1_ready", i_ready, 1);
      tick();
      present(32'h10, 16'h0002, 1'b0); #2;
      check("bp_level1", o_next_level, 1);
      tick();
      present(32'h10, 16'h0003, 1'b0); #2;
      check("bp_level2", o_next_level, 2);
      check("bp_beat3_held", i_ready, 0);
      tick(); #2;
      check("bp_still_held", i_ready, 0);
      nrdy = 1'b1; #1;
      check("full_no_bypass", i_ready, 0);
      check("bp_front1", o_next_payload, 16'h0001);
      tick();
      nrdy = 1'b0; #2;
      check("pop_level1", o_next_level, 1);
      check("bp_front2", o_next_payload, 16'h0002);
      check("retry_ready", i_ready, 1);
      tick();
      i_valid = 1'b0; #2;
      check("refill_level2", o_next_level, 2);
      nrdy = 1'b1;
      tick(); #2;
      check("bp_front3", o_next_payload, 16'h0003);
      tick();
      nrdy = 1'b0; #2;
      check("bp_empty", o_next_level, 0);

`ifdef HASH_BATCH_BCAST_EN
      // Broadcast delivered over two cycles
      lrdy = 2'b01;
      present(32'h10, 16'h00AA, 1'b1); #2;
      check("bc_c0_valid", o_local_valid, 2'b11);
      check("bc_c0_ready", i_ready, 0);
      tick();
      lrdy = 2'b10; #2;
      check("bc_c1_valid", o_local_valid, 2'b10);
      check("bc_c1_ready", i_ready, 1);
      check("bc_next_once", o_next_level, 1);
      tick();
      i_valid = 1'b0; lrdy = 2'b11; #2;
      check("bc_no_dup", o_local_valid, 2'b00);
      check("bc_next_flag", o_next_bcast, 1);
      check("bc_next_payload", o_next_payload, 16'h00AA);
      nrdy = 1'b1;
      tick();
      nrdy = 1'b0;
      // Reset in the middle of a broadcast
      lrdy = 2'b01;
      present(32'h10, 16'h00BB, 1'b1);
      tick(); #2;
      check("bc_partial", o_local_valid, 2'b10);
`else
      present(32'h00, 16'h00BB, 1'b0);
      tick(); #2;
      check("pre_rst_level", o_next_level, 1);
`endif
      rst = 1'b1; #2;
      check("midrst_local_valid", o_local_valid, 2'b00);
      check("midrst_i_ready", i_ready, 0);
      check("midrst_next_valid", o_next_valid, 0);
      check("midrst_level", o_next_level, 0);
      tick();
      rst = 1'b0; lrdy = 2'b11; nrdy = 1'b0;
`ifdef HASH_BATCH_BCAST_EN
      present(32'h10, 16'h00CC, 1'b1); #2;
      check("post_rst_bc_valid", o_local_valid, 2'b11);
      check("post_rst_bc_ready", i_ready, 1);
`else
      present(32'h10, 16'h00CC, 1'b1); #2;
      check("post_rst_bcast_ignored", o_local_valid, 2'b00);
      check("post_rst_ready", i_ready, 1);
`endif
      tick();
      i_valid = 1'b0; #2;
      check("post_rst_level", o_next_level, 1);
      nrdy = 1'b1;
      tick();
      nrdy = 1'b0;

      // Randomized traffic
      rand_rdy = 1'b1;
      counting = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] h;
         logic b;
         logic [2:0] d;
         h = AW'($urandom);
         b = 1'($urandom_range(0, 1));
         d = dest_of(h, b);
         for (int k = 0; k < 3; k++) exp_cnt[k] += int'(d[k]);
         present(h, PW'($urandom), b);
         wait_hs();
         i_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_rdy = 1'b0;
      lrdy = 2'b11; nrdy = 1'b1;
      repeat (6) tick();
      counting = 1'b0;
      check("count_port0", obs_cnt[0], exp_cnt[0]);
      check("count_port1", obs_cnt[1], exp_cnt[1]);
      check("count_next", obs_cnt[2], exp_cnt[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
